// File: rtl/and_operand_feeder_pkg.sv
// Shared types for the AND operand feeder.
//   FEEDER_WIDTH   : default operand/result width
//   operand_pair_t : one {a, b} operand pair as stored in the FIFO
//   result_rec_t   : one {a, b, y} result record as emitted downstream
//   res_state_t    : result register occupancy (EMPTY / HOLD)
package feeder_pkg;

  localparam int FEEDER_WIDTH = 4;

  typedef struct packed {
    logic [FEEDER_WIDTH-1:0] a;
    logic [FEEDER_WIDTH-1:0] b;
  } operand_pair_t;

  typedef struct packed {
    logic [FEEDER_WIDTH-1:0] a;
    logic [FEEDER_WIDTH-1:0] b;
    logic [FEEDER_WIDTH-1:0] y;
  } result_rec_t;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } res_state_t;

endpackage

// File: rtl/and_operand_feeder_if.sv
// Valid/ready streams of the AND operand feeder.
//   in_valid/in_ready/in_a/in_b          : operand pair stream into the feeder
//   out_valid/out_ready/out_a/out_b/out_y : result record stream out of the feeder
// master = producer/consumer side (bench), slave = the feeder itself.
interface and_operand_feeder_if
  import feeder_pkg::*;
#(
  parameter int WIDTH = FEEDER_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic [WIDTH-1:0] out_y;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_y
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_a, out_b, out_y
  );

endinterface

// File: rtl/and4.sv
// Purely combinational 4-bit AND unit driven by the feeder.
//   a, b : operands
//   y    : a & b
module and4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] y
);

  assign y = a & b;

endmodule

// File: rtl/and_operand_feeder_fifo.sv
// DEPTH-entry synchronous FIFO of operand pairs.
//   clk, rst_n  : clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata : write wdata at the tail (ignored when full)
//   pop         : drop the head entry (ignored when empty)
//   head        : head entry, all-zero while empty
//   full, empty : occupancy flags, decoded from registered pointers only
module operand_fifo
  import feeder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  operand_pair_t wdata,
  input  logic          pop,
  output operand_pair_t head,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit separates "full" from "empty" when the index fields match.
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  operand_pair_t mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; stale contents are never observable
  // because head is forced to zero while the pointers say the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/and_operand_feeder.sv
// Operand feeder for the combinational 4-bit AND unit.
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus (slave)  : in_* operand pair stream, out_* result record stream
//   op_a, op_b   : head pair driven to the AND unit (zero when the FIFO is empty)
//   op_y         : AND unit result, combinational on op_a/op_b
//   txn_count    : completed output handshakes, wraps modulo 2^CNT_W
// The packed record types use feeder_pkg::FEEDER_WIDTH, so WIDTH must match it.
module and_operand_feeder
  import feeder_pkg::*;
#(
  parameter int WIDTH = FEEDER_WIDTH,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  and_operand_feeder_if.slave  bus,
  output logic [WIDTH-1:0]     op_a,
  output logic [WIDTH-1:0]     op_b,
  input  logic [WIDTH-1:0]     op_y,
  output logic [CNT_W-1:0]     txn_count
);

  operand_pair_t pair_in;
  operand_pair_t head;
  result_rec_t   rec_q;
  res_state_t    state_q;
  res_state_t    state_d;
  logic          fifo_full;
  logic          fifo_empty;
  logic          ready_q;
  logic          push;
  logic          pop;
  logic          out_fire;

  // Holds in_ready low while in reset and for the reset-release edge itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_q <= 1'b0;
    else        ready_q <= 1'b1;
  end

  assign bus.in_ready = ready_q && !fifo_full;
  assign push         = bus.in_valid && bus.in_ready;
  assign pair_in      = '{a: bus.in_a, b: bus.in_b};

  // A pair pushed into an empty FIFO only becomes head after the edge, so it
  // can never be popped in the same cycle it arrives.
  assign pop      = !fifo_empty && (state_q == EMPTY || bus.out_ready);
  assign out_fire = bus.out_valid && bus.out_ready;

  operand_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (pair_in),
    .pop   (pop),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign op_a = head.a;
  assign op_b = head.b;

  // Result register state machine: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Result register state machine: next state.
  // NOTE: every combinational output gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    if (pop)                                  state_d = HOLD;
    else if (state_q == HOLD && bus.out_ready) state_d = EMPTY;
  end

  // Result register state machine: outputs.
  always_comb begin
    bus.out_valid = (state_q == HOLD);
  end

  // Captured record; held while the consumer stalls because pop is then false.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   rec_q <= '0;
    else if (pop) rec_q <= '{a: op_a, b: op_b, y: op_y};
  end

  assign bus.out_a = rec_q.a;
  assign bus.out_b = rec_q.b;
  assign bus.out_y = rec_q.y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        txn_count <= '0;
    else if (out_fire) txn_count <= txn_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_and_operand_feeder.sv
// Self-checking bench for and_operand_feeder with the and4 unit in the loop.
// A scoreboard queue receives {a, b, a&b} for every accepted input pair; a
// monitor pops and compares on every output handshake. A second instance with
// CNT_W=4 exercises counter wrap.
module tb_and_operand_feeder;
  import feeder_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  and_operand_feeder_if #(.WIDTH(4)) bus ();
  and_operand_feeder_if #(.WIDTH(4)) bus2 ();

  logic [3:0]  op_a, op_b, op_y;
  logic [15:0] txn_count;
  logic [3:0]  op_a2, op_b2, op_y2;
  logic [3:0]  txn_count2;

  and_operand_feeder #(.WIDTH(4), .DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .op_a(op_a), .op_b(op_b), .op_y(op_y), .txn_count(txn_count)
  );
  and4 u_and (.a(op_a), .b(op_b), .y(op_y));

  and_operand_feeder #(.WIDTH(4), .DEPTH(4), .CNT_W(4)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .bus(bus2),
    .op_a(op_a2), .op_b(op_b2), .op_y(op_y2), .txn_count(txn_count2)
  );
  and4 u_and2 (.a(op_a2), .b(op_b2), .y(op_y2));

  int vectors    = 0;
  int miscompares = 0;

  result_rec_t exp_q[$];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset discards everything buffered, so the expectation queue goes too.
  always @(negedge rst_n) exp_q.delete();

  // Scoreboard monitor: sample away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_record: got a=%0h b=%0h y=%0h, none expected",
                   bus.out_a, bus.out_b, bus.out_y);
        end else begin
          result_rec_t e;
          e = exp_q.pop_front();
          if (bus.out_a !== e.a || bus.out_b !== e.b || bus.out_y !== e.y) begin
            miscompares++;
            $display("FAIL record: got a=%0h b=%0h y=%0h expected a=%0h b=%0h y=%0h",
                     bus.out_a, bus.out_b, bus.out_y, e.a, e.b, e.y);
          end
        end
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back('{a: bus.in_a, b: bus.in_b, y: bus.in_a & bus.in_b});
    end
  end

  initial begin
    logic [3:0] snap_a, snap_b, snap_y;
    logic [15:0] base;
    int accepted;

    rst_n = 1'b0;
    bus.in_valid  = 1'b0; bus.in_a  = '0; bus.in_b  = '0; bus.out_ready  = 1'b1;
    bus2.in_valid = 1'b0; bus2.in_a = '0; bus2.in_b = '0; bus2.out_ready = 1'b1;

    // Reset state
    step(); step();
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_txn", txn_count, 0);
    check("rst_out_y", bus.out_y, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("idle_in_ready", bus.in_ready, 1);
    check("idle_op_a", op_a, 0);
    check("idle_op_b", op_b, 0);
    check("idle_out_valid", bus.out_valid, 0);

    // Single pair
    bus.in_valid = 1'b1; bus.in_a = 4'b0100; bus.in_b = 4'b1100;
    step();
    bus.in_valid = 1'b0;
    check("single_no_bypass", bus.out_valid, 0);
    check("single_head_a", op_a, 4'b0100);
    check("single_head_b", op_b, 4'b1100);
    step();
    check("single_valid", bus.out_valid, 1);
    check("single_out_a", bus.out_a, 4'b0100);
    check("single_out_b", bus.out_b, 4'b1100);
    check("single_out_y", bus.out_y, 4'b0100);
    step();
    check("single_txn", txn_count, 1);
    check("single_drained", bus.out_valid, 0);

    // Streaming: one record per cycle, no bubbles
    base = txn_count;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1; bus.in_a = 4'(i); bus.in_b = 4'hF;
      step();
      if (i >= 1) check("stream_no_bubble", bus.out_valid, 1);
    end
    bus.in_valid = 1'b0;
    step(); step(); step();
    check("stream_txn", txn_count, 32'(base) + 8);

    // Backpressure: DEPTH+1 pairs fit, then in_ready drops
    bus.out_ready = 1'b0;
    accepted = 0;
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = 1'b1;
      bus.in_a = 4'($urandom_range(15, 0));
      bus.in_b = 4'($urandom_range(15, 0));
      if (bus.in_ready) accepted++;
      step();
    end
    bus.in_valid = 1'b0;
    check("bp_accepted", 32'(accepted), 5);
    check("bp_in_ready", bus.in_ready, 0);
    check("bp_valid", bus.out_valid, 1);
    snap_a = bus.out_a; snap_b = bus.out_b; snap_y = bus.out_y;
    step(); step();
    check("bp_stable", {bus.out_valid, bus.out_a, bus.out_b, bus.out_y},
          {1'b1, snap_a, snap_b, snap_y});
    base = txn_count;
    bus.out_ready = 1'b1;
    step();
    check("bp_ready_return", bus.in_ready, 1);
    for (int c = 0; c < 6; c++) step();
    check("bp_drain_txn", txn_count, 32'(base) + 5);
    check("bp_empty_op_a", op_a, 0);

    // Reset mid-operation
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a = 4'($urandom_range(15, 0));
      bus.in_b = 4'($urandom_range(15, 0));
      step();
    end
    bus.in_valid = 1'b0;
    step();
    check("mid_valid_before", bus.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_out_valid", bus.out_valid, 0);
    check("mid_txn", txn_count, 0);
    check("mid_op_a", op_a, 0);
    check("mid_in_ready", bus.in_ready, 0);
    step();
    #2 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      check("post_rst_no_stale", bus.out_valid, 0);
    end
    bus.in_valid = 1'b1; bus.in_a = 4'hA; bus.in_b = 4'h6;
    step();
    bus.in_valid = 1'b0;
    step();
    check("post_rst_new_y", bus.out_y, 4'h2);
    step();
    check("post_rst_txn", txn_count, 1);

    // Random mixed traffic through the scoreboard
    for (int c = 0; c < 200; c++) begin
      bus.in_valid  = 1'($urandom_range(1, 0));
      bus.in_a      = 4'($urandom_range(15, 0));
      bus.in_b      = 4'($urandom_range(15, 0));
      bus.out_ready = 1'($urandom_range(1, 0));
      step();
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) step();
    check("final_queue_empty", 32'(exp_q.size()), 0);

    // Counter wrap on the CNT_W=4 instance: 17 handshakes -> 1
    for (int i = 0; i < 17; i++) begin
      bus2.in_valid = 1'b1;
      bus2.in_a = 4'($urandom_range(15, 0));
      bus2.in_b = 4'($urandom_range(15, 0));
      step();
    end
    bus2.in_valid = 1'b0;
    step(); step(); step();
    check("wrap_txn", txn_count2, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
